tcb_align_split: RTL

Converts unaligned TCB transfers into aligned ones. Upstream requests use reference mode: logarithmic size and LSB-aligned data, at any byte address. Downstream requests use memory mode: aligned address, byte enables and data positioned by address. A request that crosses a data-bus word boundary becomes two back-to-back downstream transfers, and the two read responses are reassembled into one upstream response. The block sits between a CPU load/store unit and aligned-only memories or peripherals on the TCB fabric.

---
 rtl/tcb_align_split.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tcb_align_split.sv
// Splits unaligned reference-mode TCB requests into aligned memory-mode transfers and
// merges split read responses. Optional splitting is enabled by `TCB_ALIGN_SPLIT_EN.
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | issuing single request or first part of split
// SECOND | second part of a split request pending
module tcb_align_split #(
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int BEN = DBW/8,
    parameter int DLY = 1
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           sub_vld,
    output logic           sub_rdy,
    input  logic           sub_wen,
    input  logic [ABW-1:0] sub_adr,
    input  logic [2:0]     sub_siz,
    input  logic [DBW-1:0] sub_wdt,
    output logic [DBW-1:0] sub_rdt,
    output logic           sub_err,
    output logic           man_vld,
    input  logic           man_rdy,
    output logic           man_wen,
    output logic [ABW-1:0] man_adr,
    output logic [BEN-1:0] man_byt,
    output logic [DBW-1:0] man_wdt,
    input  logic [DBW-1:0] man_rdt,
    input  logic           man_err
);

    localparam int OW = $clog2(BEN);
    localparam int NW = OW + 2;

    localparam logic [1:0] PH_SINGLE = 2'd0;
    localparam logic [1:0] PH_FIRST  = 2'd1;
    localparam logic [1:0] PH_SECOND = 2'd2;
    localparam logic [1:0] PH_ERROR  = 2'd3;

    typedef struct packed {
        logic          act;
        logic [1:0]    phs;
        logic          wen;
        logic [OW-1:0] off;
        logic [2:0]    siz;
    } rsp_t;

    logic [OW-1:0]    off;
    logic [NW-1:0]    n_bytes;
    logic             split;
    logic [2*BEN-1:0] byt_2w;
    logic [2*DBW-1:0] wdt_2w;
    logic [ABW-1:0]   adr_al;
    logic             second;
    logic [DBW-1:0]   hold_dat;
    logic             hold_err;
    logic             man_hs;
    logic             err_hs;
    rsp_t             push;
    rsp_t             rsp;
    rsp_t             pipe_q [DLY];
    logic [2*DBW-1:0] rdt_cat;
    logic [DBW-1:0]   rdt_shf;
    logic [NW-1:0]    rsp_n;

    assign off     = sub_adr[OW-1:0];
    assign n_bytes = NW'(1) << sub_siz;
    assign split   = (NW'(off) + n_bytes) > NW'(BEN);
    assign adr_al  = {sub_adr[ABW-1:OW], {OW{1'b0}}};

    // Low half feeds the first (or only) beat, high half spills into the next word.
    assign byt_2w = (((2*BEN)'(1) << n_bytes) - (2*BEN)'(1)) << off;
    assign wdt_2w = {{DBW{1'b0}}, sub_wdt} << {off, 3'b000};

`ifdef TCB_ALIGN_SPLIT_EN
    typedef enum logic {IDLE, SECOND} state_t;

    state_t         state_q;
    logic [DBW-1:0] hold_dat_q;
    logic           hold_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_dat_q <= '0;
            hold_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (sub_vld && man_rdy && split) state_q <= SECOND;
            end else if (man_rdy) begin
                state_q <= IDLE;
            end
            if (rsp.act && (rsp.phs == PH_FIRST)) begin
                hold_dat_q <= man_rdt;
                hold_err_q <= man_err;
            end
        end
    end

    assign second   = (state_q == SECOND);
    assign hold_dat = hold_dat_q;
    assign hold_err = hold_err_q;
    assign err_hs   = 1'b0;

    always_comb begin
        man_vld = sub_vld;
        sub_rdy = man_rdy;
        if (!second && split) sub_rdy = 1'b0;
    end
`else
    assign second   = 1'b0;
    assign hold_dat = '0;
    assign hold_err = 1'b0;
    // Crossing requests are swallowed locally and answered with an error.
    assign err_hs   = sub_vld && split;

    always_comb begin
        man_vld = sub_vld && !split;
        sub_rdy = split ? 1'b1 : man_rdy;
    end
`endif

    assign man_wen = sub_wen;
    assign man_adr = second ? (adr_al + ABW'(BEN)) : adr_al;
    assign man_byt = second ? byt_2w[2*BEN-1:BEN] : byt_2w[BEN-1:0];
    assign man_wdt = wdt_2w[DBW-1:0] | wdt_2w[2*DBW-1:DBW];
    assign man_hs  = man_vld && man_rdy;

    always_comb begin
        push.act = man_hs || err_hs;
        push.phs = PH_SINGLE;
        if (err_hs)      push.phs = PH_ERROR;
        else if (second) push.phs = PH_SECOND;
        else if (split)  push.phs = PH_FIRST;
        push.wen = sub_wen;
        push.off = off;
        push.siz = sub_siz;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DLY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= push;
            for (int i = 1; i < DLY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rsp = pipe_q[DLY-1];

    // {B, A} shifted down by the offset puts upstream byte i at the bottom.
    assign rdt_cat = (rsp.phs == PH_SECOND) ? {man_rdt, hold_dat} : {{DBW{1'b0}}, man_rdt};
    assign rdt_shf = rdt_cat[{rsp.off, 3'b000} +: DBW];
    assign rsp_n   = NW'(1) << rsp.siz;

    always_comb begin
        sub_rdt = '0;
        sub_err = 1'b0;
        if (rsp.act) begin
            case (rsp.phs)
                PH_SINGLE: sub_err = man_err;
                PH_SECOND: sub_err = man_err | hold_err;
                PH_ERROR:  sub_err = 1'b1;
                default:   sub_err = 1'b0;
            endcase
            if (!rsp.wen && ((rsp.phs == PH_SINGLE) || (rsp.phs == PH_SECOND))) begin
                for (int i = 0; i < BEN; i++) begin
                    if (NW'(i) < rsp_n) sub_rdt[8*i +: 8] = rdt_shf[8*i +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && sub_vld) assert (int'(sub_siz) <= OW);
    end
`endif

endmodule
